hour_counter: RTL and testbench
===============================

# hour_counter

Hour-of-day stage directly downstream of the minute counter. It consumes the minute counter's `hour_tick` level, which is asynchronous to `clk` and is high for one full minute period. The block synchronises that level, edge-detects it, and keeps a 0–23 hour count with 12/24-hour display conversion and a day-wrap pulse. A valid/ready set port loads the hour directly for time setting.

## Interface
- `SYNC_STAGES`, default 2: flops in the `hour_tick` synchroniser; legal values are ≥2.

- `clk`  in  1  system clock; one hour_tick high phase must span ≥ SYNC_STAGES+2 clk periods
- `reset`  in  1  asynchronous, active-high reset
- `hour_tick`  in  1  from minute counter; asynchronous to clk; each rising edge = one hour
- `mode_12h`  in  1  1 = 12-hour display, 0 = 24-hour display; static or quasi-static
- `set_valid`  in  1  set request; held high until accepted
- `set_hour`  in  5  requested hour, 24-hour encoding, legal 0–23; stable while set_valid=1
- `set_ready`  out  1  block can accept a set this cycle
- `set_err`  out  1  one-clk pulse: accepted set_hour was >23 and was discarded
- `hour24`  out  5  current hour, 0–23, registered
- `hour_disp`  out  5  display hour: 1–12 when mode_12h=1, equal to hour24 when mode_12h=0
- `pm`  out  1  1 when hour24 ≥ 12, valid in both modes
- `hour_strobe`  out  1  one-clk pulse whenever hour24 advances by tick
- `day_tick`  out  1  one-clk pulse on the 23→0 tick wrap

## Operation
- **Synchroniser:** SYNC_STAGES flops plus one edge flop `prev`. `rise = sync_out & ~prev`.
  - All synchroniser and `prev` flops reset to 1. A hour_tick held high across reset release is therefore not counted; only a later low→high transition counts.
- **Control FSM states:**
  - RUN: set_ready=1.
    - tick: on `rise`, hour24 ← (hour24==23) ? 0 : hour24+1. hour_strobe=1 that cycle; day_tick=1 too if wrapping 23→0.
    - set: on `set_valid & set_ready`, capture set_hour and go to LOAD.
  - LOAD: set_ready=0.
    - If the captured value is ≤23, hour24 ← captured value; otherwise hour24 is unchanged and set_err=1.
    - Go to WAIT.
  - WAIT: set_ready=0. Stay until set_valid=0, then go to RUN. A requester holding set_valid high never gets a second accept.
- **Simultaneous events:** the set path has priority.
  - A `rise` in the accept cycle or the LOAD cycle is discarded: no increment, no hour_strobe, no day_tick.
  - A `rise` in WAIT is applied normally.
- **Display conversion** (combinational from hour24 and mode_12h):
  - 12h mode: hour24 0 → hour_disp 12 (pm=0); 1–11 → same value (pm=0); 12 → 12 (pm=1); 13–23 → hour24−12 (pm=1).
  - 24h mode: hour_disp = hour24.
- **Widths:** all count arithmetic is 5 bits. The compare against 23 precedes the increment, so hour24 never takes a value above 23.

## Timing
- **Reset values:**
  - hour24=0, pm=0, hour_disp=12 if mode_12h else 0.
  - set_ready=0, set_err=0, hour_strobe=0, day_tick=0.
  - FSM in RUN. set_ready rises at the first clk edge after reset deasserts.
- **Tick latency:** hour_tick rising (meeting setup before edge 1) → hour24 updates on clk edge SYNC_STAGES+1, with +1 clk of uncertainty from metastability resolution. hour_strobe and day_tick are high in the cycle following that edge.
- **Set latency:** accept at edge n → hour24 updated (or set_err high) after edge n+1. set_ready returns high one edge after set_valid is seen low in WAIT.
- **Reset mid-operation:** asynchronous; all outputs and the FSM return to their reset values immediately. A pending set or tick is lost.
- All outputs except hour_disp and pm are registered. Pulse outputs are exactly one clk wide.

## Test plan
- **Reset and first tick:** reset with hour_tick=0, mode_12h=1 → hour24=0, hour_disp=12, pm=0, set_ready=1 one edge after release. Then one hour_tick pulse → hour24=1 at edge 3 (SYNC_STAGES=2), one hour_strobe.
- **Full day:** 24 hour_tick pulses from 0 → hour24 sequence 1…23,0; exactly one day_tick, coincident with the 23→0 update; 24 hour_strobes.
- **Valid set:** set_valid=1, set_hour=13, held for 5 clks, mode_12h=1 → one accept; hour24=13, hour_disp=1, pm=1; set_ready low until set_valid drops. Then set_hour=12 → hour_disp=12, pm=1.
- **Illegal set:** set_hour=25 at hour24=7 → set_err pulses once; hour24 stays 7.
- **Simultaneous events:** rise aligned with the set accept cycle (set_hour=5, prior hour24=9) → hour24=5, no hour_strobe. Next tick → hour24=6.
- **Tick held through reset:** hour_tick high while reset is asserted and released → hour24 stays 0. Drop hour_tick, then raise it → hour24=1.

Source files
------------

// File: rtl/hour_counter.sv
// Hour-of-day counter. It synchronises the minute counter's hour_tick level
// and edge-detects it, then keeps a 0-23 count with 12/24-hour display
// conversion, a day-wrap pulse and a valid/ready hour-set port.
module hour_counter #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       hour_tick,
  input  logic       mode_12h,
  input  logic       set_valid,
  input  logic [4:0] set_hour,
  output logic       set_ready,
  output logic       set_err,
  output logic [4:0] hour24,
  output logic [4:0] hour_disp,
  output logic       pm,
  output logic       hour_strobe,
  output logic       day_tick
);

  typedef enum logic [1:0] {
    S_RUN,
    S_LOAD,
    S_WAIT
  } state_t;

  state_t                 state;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;
  logic [4:0]             set_cap;
  logic [4:0]             hour_next;
  logic                   wrap;
  logic                   accept;

  // Synchroniser and edge flop reset high, so a tick held across reset
  // release is not counted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= '1;
      prev_q <= 1'b1;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], hour_tick};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  // Rising edge of the synchronised tick, the next hour value and the
  // set handshake.
  always_comb begin
    rise      = sync_q[SYNC_STAGES-1] & ~prev_q;
    wrap      = (hour24 == 5'd23);
    hour_next = wrap ? '0 : hour24 + 5'd1;
    accept    = (state == S_RUN) & set_valid & set_ready;
  end

  // Control FSM; the set path has priority over a tick in the accept and
  // LOAD cycles.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_RUN;
      set_ready   <= 1'b0;
      set_err     <= 1'b0;
      hour_strobe <= 1'b0;
      day_tick    <= 1'b0;
      hour24      <= '0;
      set_cap     <= '0;
    end else begin
      set_err     <= 1'b0;
      hour_strobe <= 1'b0;
      day_tick    <= 1'b0;
      case (state)
        S_RUN: begin
          if (accept) begin
            set_cap   <= set_hour;
            state     <= S_LOAD;
            set_ready <= 1'b0;
          end else begin
            set_ready <= 1'b1;
            if (rise) begin
              hour24      <= hour_next;
              hour_strobe <= 1'b1;
              day_tick    <= wrap;
            end
          end
        end
        S_LOAD: begin
          if (set_cap <= 5'd23) begin
            hour24 <= set_cap;
          end else begin
            set_err <= 1'b1;
          end
          state     <= S_WAIT;
          set_ready <= 1'b0;
        end
        S_WAIT: begin
          if (rise) begin
            hour24      <= hour_next;
            hour_strobe <= 1'b1;
            day_tick    <= wrap;
          end
          if (!set_valid) begin
            state     <= S_RUN;
            set_ready <= 1'b1;
          end else begin
            set_ready <= 1'b0;
          end
        end
        default: begin
          state     <= S_RUN;
          set_ready <= 1'b0;
        end
      endcase
    end
  end

  // Display conversion: 0 shows as 12, 13-23 fold down by 12 in 12h mode.
  always_comb begin
    hour_disp = hour24;
    pm        = (hour24 >= 5'd12);
    if (mode_12h) begin
      if (hour24 == 5'd0) begin
        hour_disp = 5'd12;
      end else if (hour24 > 5'd12) begin
        hour_disp = hour24 - 5'd12;
      end
    end
  end

endmodule

// File: tb/tb_hour_counter.sv
// Directed testbench for hour_counter with a scoreboard of expected tick
// results that is drained by a monitor on each hour_strobe.
module tb_hour_counter;

  logic       clk;
  logic       reset;
  logic       hour_tick;
  logic       mode_12h;
  logic       set_valid;
  logic [4:0] set_hour;
  logic       set_ready;
  logic       set_err;
  logic [4:0] hour24;
  logic [4:0] hour_disp;
  logic       pm;
  logic       hour_strobe;
  logic       day_tick;

  typedef struct {
    int h;
    int d;
  } exp_t;

  exp_t sb[$];
  exp_t mon_e;

  int checks       = 0;
  int errors       = 0;
  int strobe_count = 0;
  int day_count    = 0;
  int err_count    = 0;
  int accepts      = 0;
  int base;

  hour_counter #(.SYNC_STAGES(2)) dut (
    .clk        (clk),
    .reset      (reset),
    .hour_tick  (hour_tick),
    .mode_12h   (mode_12h),
    .set_valid  (set_valid),
    .set_hour   (set_hour),
    .set_ready  (set_ready),
    .set_err    (set_err),
    .hour24     (hour24),
    .hour_disp  (hour_disp),
    .pm         (pm),
    .hour_strobe(hour_strobe),
    .day_tick   (day_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // One hour_tick pulse with its expected result queued beforehand.
  task automatic tick(input int h, input int d);
    sb.push_back('{h: h, d: d});
    @(posedge clk); #2 hour_tick = 1'b1;
    repeat (6) @(posedge clk);
    #2 hour_tick = 1'b0;
    repeat (6) @(posedge clk);
    #2;
    chk("tick_drained", sb.size(), 0);
  endtask

  // Single-cycle set request issued while the block is ready.
  task automatic do_set(input logic [4:0] h);
    @(posedge clk); #2 set_valid = 1'b1; set_hour = h;
    @(posedge clk); #2 set_valid = 1'b0;
    repeat (2) @(posedge clk);
    #2;
  endtask

  // Monitor: pop the scoreboard on each strobe and count pulses.
  always @(negedge clk) begin
    if (set_valid && set_ready) accepts++;
    if (set_err) err_count++;
    if (day_tick) day_count++;
    if (hour_strobe) begin
      strobe_count++;
      if (sb.size() == 0) begin
        chk("strobe_unexpected", int'(hour_strobe), 0);
      end else begin
        mon_e = sb.pop_front();
        chk("tick_hour24", int'(hour24), mon_e.h);
        chk("tick_day", int'(day_tick), mon_e.d);
      end
    end else if (day_tick) begin
      chk("day_without_strobe", int'(day_tick), 0);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; hour_tick = 1'b0; mode_12h = 1'b1;
    set_valid = 1'b0; set_hour = '0;

    // Reset state
    @(negedge clk);
    chk("rst_hour24", int'(hour24), 0);
    chk("rst_disp12", int'(hour_disp), 12);
    chk("rst_pm", int'(pm), 0);
    chk("rst_ready", int'(set_ready), 0);
    chk("rst_err", int'(set_err), 0);
    chk("rst_strobe", int'(hour_strobe), 0);
    chk("rst_day", int'(day_tick), 0);
    @(posedge clk); #2 reset = 1'b0;
    @(negedge clk);
    chk("ready_before_edge", int'(set_ready), 0);
    @(negedge clk);
    chk("ready_after_edge", int'(set_ready), 1);

    // First tick, then the rest of the day through the wrap
    tick(1, 0);
    chk("first_strobes", strobe_count, 1);
    for (int i = 2; i <= 23; i++) tick(i, 0);
    tick(0, 1);
    chk("day_strobes", strobe_count, 24);
    chk("day_ticks", day_count, 1);
    chk("day_hour24", int'(hour24), 0);

    // Valid set held for 5 clocks: one accept only
    base = accepts;
    @(posedge clk); #2 set_valid = 1'b1; set_hour = 5'd13;
    @(negedge clk);
    chk("set_ready_pre", int'(set_ready), 1);
    repeat (4) @(negedge clk);
    chk("set13_hour24", int'(hour24), 13);
    chk("set13_disp", int'(hour_disp), 1);
    chk("set13_pm", int'(pm), 1);
    chk("set13_ready_held", int'(set_ready), 0);
    chk("set13_accepts", accepts - base, 1);
    @(posedge clk); #2 set_valid = 1'b0;
    @(negedge clk);
    chk("ready_wait_low", int'(set_ready), 0);
    @(negedge clk);
    chk("ready_return", int'(set_ready), 1);

    do_set(5'd12);
    chk("set12_hour24", int'(hour24), 12);
    chk("set12_disp", int'(hour_disp), 12);
    chk("set12_pm", int'(pm), 1);

    // 24h display
    mode_12h = 1'b0;
    do_set(5'd17);
    chk("h24_disp", int'(hour_disp), 17);
    chk("h24_pm", int'(pm), 1);
    do_set(5'd0);
    chk("h24_disp0", int'(hour_disp), 0);
    mode_12h = 1'b1;
    #1 chk("h12_disp0", int'(hour_disp), 12);

    // Illegal set is discarded with a one-clock error pulse
    do_set(5'd7);
    chk("set7_hour24", int'(hour24), 7);
    base = err_count;
    @(posedge clk); #2 set_valid = 1'b1; set_hour = 5'd25;
    @(posedge clk); #2 set_valid = 1'b0;
    @(negedge clk);
    chk("err_accept_cycle", int'(set_err), 0);
    @(negedge clk);
    chk("err_pulse", int'(set_err), 1);
    chk("err_hour24", int'(hour24), 7);
    @(negedge clk);
    chk("err_pulse_end", int'(set_err), 0);
    chk("err_count", err_count - base, 1);
    chk("err_hour24_kept", int'(hour24), 7);

    // Rise lands in the accept cycle: set wins, tick discarded
    do_set(5'd9);
    chk("set9_hour24", int'(hour24), 9);
    base = strobe_count;
    @(posedge clk); #2 hour_tick = 1'b1;
    @(posedge clk);
    @(posedge clk); #2 set_valid = 1'b1; set_hour = 5'd5;
    @(posedge clk); #2 set_valid = 1'b0;
    repeat (6) @(posedge clk);
    #2 hour_tick = 1'b0;
    repeat (4) @(posedge clk);
    #2;
    chk("simul_hour24", int'(hour24), 5);
    chk("simul_no_strobe", strobe_count - base, 0);
    tick(6, 0);

    // Asynchronous reset mid-run, with hour_tick held through release
    base = strobe_count;
    @(posedge clk); #2 reset = 1'b1;
    #1;
    chk("async_rst_hour24", int'(hour24), 0);
    chk("async_rst_disp", int'(hour_disp), 12);
    chk("async_rst_ready", int'(set_ready), 0);
    hour_tick = 1'b1;
    repeat (3) @(posedge clk);
    #2 reset = 1'b0;
    repeat (8) @(posedge clk);
    #2;
    chk("held_tick_hour24", int'(hour24), 0);
    chk("held_tick_ready", int'(set_ready), 1);
    chk("held_tick_strobes", strobe_count - base, 0);
    hour_tick = 1'b0;
    repeat (4) @(posedge clk);
    tick(1, 0);
    chk("post_rst_hour24", int'(hour24), 1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
